// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE ALL,
// two AUTO REFRESH, LOAD MODE REGISTER, then a sticky Init_done.
module sdram_init_ctrl #(
  parameter int unsigned      ASIZE     = 12,
  parameter int unsigned      T_POWERUP = 20000,
  parameter int unsigned      T_RP      = 2,
  parameter int unsigned      T_RC      = 7,
  parameter int unsigned      T_MRD     = 2,
  parameter logic [ASIZE-1:0] MODE_REG  = ASIZE'(12'h032)
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic [3:0]       Command,
  output logic [ASIZE-1:0] Saddr,
  output logic             Init_done
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam int unsigned T_MAX_A = (T_POWERUP > T_RC)  ? T_POWERUP : T_RC;
  localparam int unsigned T_MAX_B = (T_RP > T_MRD)      ? T_RP      : T_MRD;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A   : T_MAX_B;
  localparam int unsigned CW      = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

  // Gap states are entered one cycle after their command, so they exit at
  // count T_x-2; a gap of 1 skips the gap state entirely.
  localparam logic [CW-1:0] PWR_END = CW'(T_POWERUP);
  localparam logic [CW-1:0] RP_END  = CW'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CW-1:0] RC_END  = CW'((T_RC  > 1) ? T_RC  - 2 : 0);
  localparam logic [CW-1:0] MRD_END = CW'((T_MRD > 1) ? T_MRD - 2 : 0);

  // A10 selects all banks; narrower buses have no A10 to drive.
  localparam logic [ASIZE-1:0] PRE_ADDR = ASIZE'((ASIZE > 10) ? (1 << 10) : 0);

  typedef enum logic [3:0] {
    S_WAIT, S_PRE, S_TRP, S_REF1, S_TRC1, S_REF2, S_TRC2, S_LMR, S_TMRD, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [3:0]       cmd_nx;
  logic [ASIZE-1:0] addr_nx;
  logic             done_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT: if (cnt == PWR_END) state_nx = S_PRE;
      S_PRE:  state_nx = (T_RP  <= 1) ? S_REF1 : S_TRP;
      S_TRP:  if (cnt == RP_END) state_nx = S_REF1;
      S_REF1: state_nx = (T_RC  <= 1) ? S_REF2 : S_TRC1;
      S_TRC1: if (cnt == RC_END) state_nx = S_REF2;
      S_REF2: state_nx = (T_RC  <= 1) ? S_LMR  : S_TRC2;
      S_TRC2: if (cnt == RC_END) state_nx = S_LMR;
      S_LMR:  state_nx = (T_MRD <= 1) ? S_DONE : S_TMRD;
      S_TMRD: if (cnt == MRD_END) state_nx = S_DONE;
      S_DONE: state_nx = S_DONE;
      default: state_nx = S_WAIT;
    endcase
  end

  always_comb begin
    cnt_nx = cnt + CW'(1);
    if (state_nx != state) cnt_nx = '0;
    else if (state == S_DONE) cnt_nx = cnt;
  end

  // Outputs are decoded from the next state so the registered command
  // appears in the same cycle the FSM enters its state.
  always_comb begin
    cmd_nx  = CMD_NOP;
    addr_nx = '0;
    done_nx = 1'b0;
    case (state_nx)
      S_PRE: begin
        cmd_nx  = CMD_PRE;
        addr_nx = PRE_ADDR;
      end
      S_REF1, S_REF2: cmd_nx = CMD_REF;
      S_LMR: begin
        cmd_nx  = CMD_LMR;
        addr_nx = MODE_REG;
      end
      S_DONE: done_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_WAIT;
      cnt       <= '0;
      Command   <= CMD_NOP;
      Saddr     <= '0;
      Init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      Command   <= cmd_nx;
      Saddr     <= addr_nx;
      Init_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Scoreboard bench for sdram_init_ctrl: default-timing instance plus a
// short-timing instance; expected commands are queued before release.
module tb_sdram_init_ctrl;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

  typedef struct { int cyc; logic [3:0] c; logic [11:0] a; } ev_t;

  logic        clk = 1'b0, rst = 1'b1, rst_f = 1'b1;
  logic [3:0]  cmd, cmd_f;
  logic [11:0] saddr, saddr_f;
  logic        done, done_f;
  logic        done_d = 1'b0, done_fd = 1'b0;
  int n_chk = 0, n_pass = 0;
  int cyc = -1, cyc_f = -1, done_cyc = -1, done_cyc_f = -1;
  ev_t exp_q[$], obs_q[$], exp_fq[$], obs_fq[$];

  always #5 clk = ~clk;

  sdram_init_ctrl dut (
    .Clk(clk), .Rst(rst), .Command(cmd), .Saddr(saddr), .Init_done(done)
  );

  sdram_init_ctrl #(.T_POWERUP(10), .T_RP(1), .T_RC(1), .T_MRD(1)) dut_f (
    .Clk(clk), .Rst(rst_f), .Command(cmd_f), .Saddr(saddr_f), .Init_done(done_f)
  );

  // cycle n is the period following the n-th edge with reset low
  always @(posedge clk) begin
    cyc   = rst   ? -1 : cyc + 1;
    cyc_f = rst_f ? -1 : cyc_f + 1;
  end

  always @(negedge clk) begin
    if (cmd !== NOP) obs_q.push_back('{cyc, cmd, saddr});
    if (done === 1'b1 && done_d !== 1'b1) done_cyc = cyc;
    done_d = done;
    if (cmd_f !== NOP) obs_fq.push_back('{cyc_f, cmd_f, saddr_f});
    if (done_f === 1'b1 && done_fd !== 1'b1) done_cyc_f = cyc_f;
    done_fd = done_f;
  end

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd !== NOP || saddr !== 12'h000 || done !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL reset_state: got %0d bad cycles (cmd=%b addr=%h done=%b), required 0", bad, cmd, saddr, done);
    else n_pass++;
  endtask

  task automatic test_sequence();
    ev_t e, o;
    logic [11:0] mode = '0;
    int bad = 0;
    exp_q.delete(); obs_q.delete(); done_cyc = -1;
    exp_q.push_back('{20000, PRE, 12'h400});
    exp_q.push_back('{20002, REF, 12'h000});
    exp_q.push_back('{20009, REF, 12'h000});
    exp_q.push_back('{20016, LMR, 12'h032});
    rst = 1'b0;
    for (int i = 0; i < 25000 && done !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (done_cyc != 20018) $display("FAIL seq_done_cycle: got %0d, required 20018", done_cyc);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL seq_missing: got none, required cmd=%b at cycle %0d", e.c, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.c === LMR) mode = o.a;
        if (o.cyc != e.cyc || o.c !== e.c || o.a !== e.a)
          $display("FAIL seq_cmd: got cmd=%b addr=%h cycle %0d, required cmd=%b addr=%h cycle %0d", o.c, o.a, o.cyc, e.c, e.a, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL seq_extra: got %0d extra commands, required 0", obs_q.size());
    else n_pass++;
    n_chk++;
    if (mode[6:4] !== 3'd3 || (1 << mode[2:0]) != 4 || mode[3] !== 1'b0)
      $display("FAIL mode_decode: got cas=%0d bl=%0d bt=%b, required cas=3 bl=4 bt=0", mode[6:4], 1 << mode[2:0], mode[3]);
    else n_pass++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd !== NOP || saddr !== 12'h000 || done !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL done_stable: got %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_done_reset();
    n_chk++;
    if (done !== 1'b1 || cmd !== NOP) $display("FAIL done_hold: got done=%b cmd=%b, required done=1 cmd=%b", done, cmd, NOP);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || cmd !== NOP || saddr !== 12'h000)
      $display("FAIL done_reset: got done=%b cmd=%b addr=%h, required done=0 cmd=%b addr=000", done, cmd, saddr, NOP);
    else n_pass++;
    exp_q.delete(); obs_q.delete(); done_cyc = -1;
    exp_q.push_back('{20000, PRE, 12'h400});
    exp_q.push_back('{20002, REF, 12'h000});
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    ev_t e, o;
    for (int i = 0; i < 25000 && cyc != 20004; i++) @(negedge clk);
    n_chk++;
    if (cyc != 20004) $display("FAIL mid_reach: got cycle %0d, required 20004", cyc);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || cmd !== NOP) $display("FAIL mid_reset: got done=%b cmd=%b, required done=0 cmd=%b", done, cmd, NOP);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL mid_missing: got none, required cmd=%b at cycle %0d", e.c, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.c !== e.c || o.a !== e.a)
          $display("FAIL mid_cmd: got cmd=%b addr=%h cycle %0d, required cmd=%b addr=%h cycle %0d", o.c, o.a, o.cyc, e.c, e.a, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL mid_extra: got %0d extra commands, required 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_abort_restart();
    ev_t e, o;
    exp_q.delete(); obs_q.delete(); done_cyc = -1;
    exp_q.push_back('{20000, PRE, 12'h400});
    exp_q.push_back('{20002, REF, 12'h000});
    exp_q.push_back('{20009, REF, 12'h000});
    exp_q.push_back('{20016, LMR, 12'h032});
    rst = 1'b0;
    for (int i = 0; i < 25000 && done !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (done_cyc != 20018) $display("FAIL restart_done_cycle: got %0d, required 20018", done_cyc);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL restart_missing: got none, required cmd=%b at cycle %0d", e.c, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.c !== e.c || o.a !== e.a)
          $display("FAIL restart_cmd: got cmd=%b addr=%h cycle %0d, required cmd=%b addr=%h cycle %0d", o.c, o.a, o.cyc, e.c, e.a, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL restart_extra: got %0d extra commands, required 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_fast_timing();
    ev_t e, o;
    exp_fq.delete(); obs_fq.delete(); done_cyc_f = -1;
    exp_fq.push_back('{10, PRE, 12'h400});
    exp_fq.push_back('{11, REF, 12'h000});
    exp_fq.push_back('{12, REF, 12'h000});
    exp_fq.push_back('{13, LMR, 12'h032});
    rst_f = 1'b0;
    for (int i = 0; i < 40 && done_f !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (done_cyc_f != 14) $display("FAIL fast_done_cycle: got %0d, required 14", done_cyc_f);
    else n_pass++;
    while (exp_fq.size() > 0) begin
      e = exp_fq.pop_front();
      n_chk++;
      if (obs_fq.size() == 0) $display("FAIL fast_missing: got none, required cmd=%b at cycle %0d", e.c, e.cyc);
      else begin
        o = obs_fq.pop_front();
        if (o.cyc != e.cyc || o.c !== e.c || o.a !== e.a)
          $display("FAIL fast_cmd: got cmd=%b addr=%h cycle %0d, required cmd=%b addr=%h cycle %0d", o.c, o.a, o.cyc, e.c, e.a, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_fq.size() != 0) $display("FAIL fast_extra: got %0d extra commands, required 0", obs_fq.size());
    else n_pass++;
  endtask

  task automatic test_reset_hold();
    int bad = 0;
    obs_q.delete();
    rst = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (cmd !== NOP || saddr !== 12'h000 || done !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0 || obs_q.size() != 0)
      $display("FAIL reset_hold: got %0d bad cycles and %0d commands, required 0 and 0", bad, obs_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_done_reset();
    test_mid_reset();
    test_abort_restart();
    test_fast_timing();
    test_reset_hold();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
